ex_operand_stage: RTL

ID/EX pipeline register and operand-forwarding stage of the RV32I core; sits directly upstream of the combinational ALU and drives its A1, A2 and aluCont inputs. Captures a decoded-stage instruction, generates the immediate and the 4-bit ALU control code, selects forwarded operands from EX/MEM and MEM/WB, and detects load-use hazards. Valid/ready handshake on both sides; stall, bubble and flush handled internally.

---
 rtl/ex_operand_stage.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with immediate/ALU-control generation, operand forwarding and
// load-use hazard detection. Define EX_OPERAND_FWD_EN to enable the forwarding muxes.
module ex_operand_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic [4:0]        exmem_rd,
  input  logic              exmem_regwrite,
  input  logic              exmem_memread,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [4:0]        memwb_rd,
  input  logic              memwb_regwrite,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_A1,
  output logic [DATA_W-1:0] ex_A2,
  output logic [3:0]        ex_aluCont,
  output logic [4:0]        ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_illegal,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [DATA_W-1:0] ex_pc
);

  typedef enum logic [2:0] {
    KindOp, KindOpImm, KindLoad, KindStore, KindLui, KindAuipc, KindIll
  } kind_e;

  logic [2:0]        funct3;
  logic [4:0]        dec_rs1, dec_rs2;
  kind_e             dec_kind;
  logic [DATA_W-1:0] dec_imm;
  logic [3:0]        dec_aluc;
  logic [4:0]        dec_rd;
  logic              dec_rw, dec_mr, dec_mw, dec_ill, dec_use1, dec_use2;
  logic              hazard;

  logic              valid_d, valid_q, rw_d, rw_q, mr_d, mr_q, mw_d, mw_q, ill_d, ill_q;
  kind_e             kind_d, kind_q;
  logic [3:0]        aluc_d, aluc_q;
  logic [4:0]        rd_d, rd_q, rs1_d, rs1_q, rs2_d, rs2_q;
  logic [DATA_W-1:0] pc_d, pc_q, imm_d, imm_q;
  logic [DATA_W-1:0] rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q;
  logic [DATA_W-1:0] rs1_val, rs2_val;

  assign funct3  = id_instr[14:12];
  assign dec_rs1 = id_instr[19:15];
  assign dec_rs2 = id_instr[24:20];

  always_comb begin
    dec_kind = KindIll;
    case (id_instr[6:0])
      7'b0110011: dec_kind = KindOp;
      7'b0010011: dec_kind = KindOpImm;
      7'b0000011: dec_kind = KindLoad;
      7'b0100011: dec_kind = KindStore;
      7'b0110111: dec_kind = KindLui;
      7'b0010111: dec_kind = KindAuipc;
      default:    dec_kind = KindIll;
    endcase
  end

  always_comb begin
    dec_imm  = '0;
    dec_aluc = 4'b0000;
    dec_rw   = 1'b0;
    dec_mr   = 1'b0;
    dec_mw   = 1'b0;
    dec_ill  = 1'b0;
    dec_use1 = 1'b1;
    dec_use2 = 1'b0;
    unique case (dec_kind)
      KindOp: begin
        dec_aluc = {id_instr[30], funct3};
        dec_rw   = 1'b1;
        dec_use2 = 1'b1;
      end
      KindOpImm: begin
        dec_aluc = {(funct3 == 3'b101) & id_instr[30], funct3};
        // Shifts carry only the shamt; funct7 bits select the shift type.
        dec_imm  = (funct3[1:0] == 2'b01) ? {27'b0, id_instr[24:20]}
                                          : {{20{id_instr[31]}}, id_instr[31:20]};
        dec_rw   = 1'b1;
      end
      KindLoad: begin
        dec_imm = {{20{id_instr[31]}}, id_instr[31:20]};
        dec_rw  = 1'b1;
        dec_mr  = 1'b1;
      end
      KindStore: begin
        dec_imm  = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
        dec_mw   = 1'b1;
        dec_use2 = 1'b1;
      end
      KindLui, KindAuipc: begin
        dec_imm  = {id_instr[31:12], 12'b0};
        dec_rw   = 1'b1;
        dec_use1 = 1'b0;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign dec_rd = dec_rw ? id_instr[11:7] : 5'd0;

`ifdef EX_OPERAND_FWD_EN
  assign hazard = id_valid && valid_q && mr_q && (rd_q != 5'd0) &&
                  ((dec_use1 && dec_rs1 == rd_q) || (dec_use2 && dec_rs2 == rd_q));

  always_comb begin
    rs1_val = rs1_data_q;
    rs2_val = rs2_data_q;
    if (exmem_regwrite && !exmem_memread && exmem_rd != 5'd0 && exmem_rd == rs1_q) begin
      rs1_val = exmem_result;
    end else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == rs1_q) begin
      rs1_val = memwb_result;
    end
    if (exmem_regwrite && !exmem_memread && exmem_rd != 5'd0 && exmem_rd == rs2_q) begin
      rs2_val = exmem_result;
    end else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == rs2_q) begin
      rs2_val = memwb_result;
    end
  end
`else
  // Without forwarding, wait until the producer reaches MEM/WB (write-first regfile).
  assign hazard = id_valid && (
      (valid_q && rw_q && (rd_q != 5'd0) &&
       ((dec_use1 && dec_rs1 == rd_q) || (dec_use2 && dec_rs2 == rd_q))) ||
      (exmem_regwrite && (exmem_rd != 5'd0) &&
       ((dec_use1 && dec_rs1 == exmem_rd) || (dec_use2 && dec_rs2 == exmem_rd))));

  assign rs1_val = rs1_data_q;
  assign rs2_val = rs2_data_q;

  logic unused_fwd;
  assign unused_fwd = ^{exmem_memread, exmem_result, memwb_rd, memwb_regwrite, memwb_result};
`endif

  assign id_ready = flush | (ex_ready & ~hazard);

  always_comb begin
    valid_d    = valid_q;
    kind_d     = kind_q;
    aluc_d     = aluc_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rw_d       = rw_q;
    mr_d       = mr_q;
    mw_d       = mw_q;
    ill_d      = ill_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    if (flush || ex_ready) begin
      if (flush || hazard || !id_valid) begin
        valid_d = 1'b0;
        aluc_d  = 4'b0000;
        rd_d    = 5'd0;
        rw_d    = 1'b0;
        mr_d    = 1'b0;
        mw_d    = 1'b0;
        ill_d   = 1'b0;
      end else begin
        valid_d    = 1'b1;
        kind_d     = dec_kind;
        aluc_d     = dec_aluc;
        rd_d       = dec_rd;
        rs1_d      = dec_rs1;
        rs2_d      = dec_rs2;
        rw_d       = dec_rw;
        mr_d       = dec_mr;
        mw_d       = dec_mw;
        ill_d      = dec_ill;
        pc_d       = id_pc;
        imm_d      = dec_imm;
        rs1_data_d = id_rs1_data;
        rs2_data_d = id_rs2_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      kind_q     <= KindOp;
      aluc_q     <= 4'b0000;
      rd_q       <= 5'd0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      rw_q       <= 1'b0;
      mr_q       <= 1'b0;
      mw_q       <= 1'b0;
      ill_q      <= 1'b0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      valid_q    <= valid_d;
      kind_q     <= kind_d;
      aluc_q     <= aluc_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rw_q       <= rw_d;
      mr_q       <= mr_d;
      mw_q       <= mw_d;
      ill_q      <= ill_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

  always_comb begin
    ex_A1 = rs1_val;
    ex_A2 = imm_q;
    unique case (kind_q)
      KindOp:           ex_A2 = rs2_val;
      KindLui:          ex_A1 = '0;
      KindAuipc:        ex_A1 = pc_q;
      KindIll: begin
        ex_A1 = '0;
        ex_A2 = '0;
      end
      default: ;
    endcase
  end

  assign ex_valid      = valid_q;
  assign ex_aluCont    = aluc_q;
  assign ex_rd         = rd_q;
  assign ex_regwrite   = rw_q;
  assign ex_memread    = mr_q;
  assign ex_memwrite   = mw_q;
  assign ex_illegal    = ill_q;
  assign ex_store_data = rs2_val;
  assign ex_pc         = pc_q;

endmodule
